// File: rtl/dcache_direct.sv
// dcache_direct
//   Direct-mapped, write-back, write-allocate data cache. It sits between
//   the CPU D-cache port and a memory that transfers whole lines.
//   Hits are answered combinationally with no stall. A miss holds
//   proc_stall high while the cache writes back a dirty victim, if there
//   is one, and then refills the line. After the refill the request
//   completes as a hit.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   proc_read / proc_write    word request (write wins if both are high)
//   proc_addr[29:0]           word address {tag, index, offset[1:0]}
//   proc_wdata[31:0]          write data
//   proc_stall                request not complete this cycle
//   proc_rdata[31:0]          read data (valid when read && !stall)
//   mem_read / mem_write      registered line requests (never both high)
//   mem_addr[27:0]            registered line address {tag, index}
//   mem_wdata[127:0]          registered victim line, word 0 in [31:0]
//   mem_rdata[127:0]          refill line, valid while mem_ready is high
//   mem_ready                 one-cycle completion pulse from memory

module dcache_direct #(
    parameter int NUM_LINES = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           proc_read,
    input  logic           proc_write,
    input  logic [29:0]    proc_addr,
    input  logic [31:0]    proc_wdata,
    output logic           proc_stall,
    output logic [31:0]    proc_rdata,
    output logic           mem_read,
    output logic           mem_write,
    output logic [27:0]    mem_addr,
    output logic [127:0]   mem_wdata,
    input  logic [127:0]   mem_rdata,
    input  logic           mem_ready
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [NUM_LINES-1:0]   valid_r;
    logic [NUM_LINES-1:0]   dirty_r;
    logic [TAG_W-1:0]       tag_arr_r  [NUM_LINES];
    logic [127:0]           data_arr_r [NUM_LINES];

    logic [1:0]             off_s;
    logic [IDX_W-1:0]       idx_s;
    logic [TAG_W-1:0]       tag_s;
    logic                   req_s;
    logic                   hit_s;
    logic                   victim_dirty_s;
    logic [127:0]           line_s;
    logic [127:0]           merged_line_s;

    assign off_s = proc_addr[1:0];
    assign idx_s = proc_addr[IDX_W+1:2];
    assign tag_s = proc_addr[29:IDX_W+2];
    assign req_s = proc_read | proc_write;

    // Lookup of the indexed line: hit detection, victim status, and write merge.
    always_comb begin
        line_s         = data_arr_r[idx_s];
        hit_s          = valid_r[idx_s] && (tag_arr_r[idx_s] == tag_s);
        victim_dirty_s = valid_r[idx_s] && dirty_r[idx_s];
        merged_line_s  = line_s;
        merged_line_s[{off_s, 5'd0} +: 32] = proc_wdata;
    end

    // Processor-side outputs: stall is combinational in IDLE and forced during a miss.
    always_comb begin
        proc_stall = 1'b1;
        proc_rdata = line_s[{off_s, 5'd0} +: 32];
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    proc_stall = ~hit_s;
                end else begin
                    proc_stall = 1'b0;
                end
            end
            default: begin
                proc_stall = 1'b1;
            end
        endcase
    end

    // Miss FSM with registered memory-side outputs and per-line valid/dirty flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 28'd0;
            mem_wdata <= 128'd0;
            valid_r   <= {NUM_LINES{1'b0}};
            dirty_r   <= {NUM_LINES{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        if (hit_s) begin
                            if (proc_write) begin
                                dirty_r[idx_s] <= 1'b1;
                            end
                        end else if (victim_dirty_s) begin
                            // Evict first; the refill address is loaded when the write-back completes.
                            mem_write <= 1'b1;
                            mem_read  <= 1'b0;
                            mem_addr  <= {tag_arr_r[idx_s], idx_s};
                            mem_wdata <= line_s;
                            state_r   <= ST_WRITEBACK;
                        end else begin
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                            mem_addr  <= {tag_s, idx_s};
                            state_r   <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= {tag_s, idx_s};
                        state_r   <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        mem_read       <= 1'b0;
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                        state_r        <= ST_IDLE;
                    end
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if ((state_r == ST_ALLOCATE) && mem_ready) begin
            data_arr_r[idx_s] <= mem_rdata;
            tag_arr_r[idx_s]  <= tag_s;
        end else if ((state_r == ST_IDLE) && proc_write && hit_s) begin
            data_arr_r[idx_s] <= merged_line_s;
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
module tb_dcache_direct;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           proc_read = 1'b0;
    logic           proc_write = 1'b0;
    logic [29:0]    proc_addr = 30'd0;
    logic [31:0]    proc_wdata = 32'd0;
    logic           proc_stall;
    logic [31:0]    proc_rdata;
    logic           mem_read;
    logic           mem_write;
    logic [27:0]    mem_addr;
    logic [127:0]   mem_wdata;
    logic [127:0]   mem_rdata = 128'd0;
    logic           mem_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model and traffic log
    logic [127:0]   mem_m [32];
    int             lat = 0;
    int             wcnt = 0;
    int             rd_cnt = 0;
    int             wr_cnt = 0;
    logic [27:0]    rd_addr_seen = 28'd0;
    logic [27:0]    wr_addr_seen = 28'd0;
    logic [127:0]   wr_data_seen = 128'd0;
    int             both_cnt = 0;

    localparam logic [127:0] LINE1 = {32'hDDDD_0001, 32'hCCCC_0001, 32'hBBBB_0001, 32'hAAAA_0001};
    localparam logic [127:0] LINE9 = {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000};
    localparam logic [127:0] LINE2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
    localparam logic [127:0] LINE3 = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

    dcache_direct #(.NUM_LINES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    // memory responder: answers after 'lat' extra cycles, logs traffic
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_read && mem_write) both_cnt++;
            if (rst) begin
                wcnt = 0;
            end else if (mem_read || mem_write) begin
                if (mem_read) begin
                    rd_cnt++;
                    rd_addr_seen = mem_addr;
                end
                if (mem_write) begin
                    wr_cnt++;
                    wr_addr_seen = mem_addr;
                    wr_data_seen = mem_wdata;
                end
                if (wcnt >= lat) begin
                    wcnt = 0;
                    mem_ready = 1'b1;
                    if (mem_write) mem_m[mem_addr[4:0]] = mem_wdata;
                    else mem_rdata = mem_m[mem_addr[4:0]];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [29:0] a,
                             input logic [31:0] wd, output int stalls, output logic [31:0] rdo);
        int cyc;
        @(negedge clk);
        rd_cnt = 0;
        wr_cnt = 0;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        #1;
        cyc = 0;
        while (proc_stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        if (cyc >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL access_timeout addr=%h stall still high after %0d cycles", a, cyc);
        end
        stalls = cyc;
        rdo = proc_rdata;
        @(negedge clk);
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
        n_cmp++; if (mem_addr !== 28'd0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 128'd0) begin n_bad++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (proc_stall !== 1'b0) begin n_bad++; $display("FAIL reset_idle_stall got %b want 0", proc_stall); end
    endtask

    task automatic test_cold_read();
        int st; logic [31:0] rd;
        lat = 2;
        do_access(1'b1, 1'b0, 30'h5, 32'd0, st, rd);
        n_cmp++; if (rd !== 32'hBBBB_0001) begin n_bad++; $display("FAIL cold_rdata got %h want BBBB0001", rd); end
        n_cmp++; if (rd_cnt == 0) begin n_bad++; $display("FAIL cold_mem_read got %0d cycles want >0", rd_cnt); end
        n_cmp++; if (rd_addr_seen !== 28'h1) begin n_bad++; $display("FAIL cold_mem_addr got %h want 1", rd_addr_seen); end
        n_cmp++; if (wr_cnt != 0) begin n_bad++; $display("FAIL cold_no_write got %0d want 0", wr_cnt); end
        n_cmp++; if (st != 4) begin n_bad++; $display("FAIL cold_stall_cycles got %0d want 4", st); end
    endtask

    task automatic test_read_hit();
        int st; logic [31:0] rd;
        do_access(1'b1, 1'b0, 30'h6, 32'd0, st, rd);
        n_cmp++; if (rd !== 32'hCCCC_0001) begin n_bad++; $display("FAIL hit_rdata got %h want CCCC0001", rd); end
        n_cmp++; if (st != 0) begin n_bad++; $display("FAIL hit_stall got %0d want 0", st); end
        n_cmp++; if (rd_cnt + wr_cnt != 0) begin n_bad++; $display("FAIL hit_traffic got %0d want 0", rd_cnt + wr_cnt); end
    endtask

    task automatic test_write_hit();
        int st; logic [31:0] rd;
        do_access(1'b0, 1'b1, 30'h4, 32'hDEAD_BEEF, st, rd);
        n_cmp++; if (st != 0) begin n_bad++; $display("FAIL wr_hit_stall got %0d want 0", st); end
        do_access(1'b1, 1'b0, 30'h4, 32'd0, st, rd);
        n_cmp++; if (st != 0) begin n_bad++; $display("FAIL wr_rd_stall got %0d want 0", st); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rd_rdata got %h want DEADBEEF", rd); end
        n_cmp++; if (rd_cnt + wr_cnt != 0) begin n_bad++; $display("FAIL wr_hit_traffic got %0d want 0", rd_cnt + wr_cnt); end
    endtask

    task automatic test_dirty_conflict();
        int st; logic [31:0] rd;
        lat = 1;
        do_access(1'b1, 1'b0, 30'h24, 32'd0, st, rd);
        n_cmp++; if (wr_cnt == 0) begin n_bad++; $display("FAIL dirty_mem_write got %0d cycles want >0", wr_cnt); end
        n_cmp++; if (wr_addr_seen !== 28'h1) begin n_bad++; $display("FAIL dirty_wb_addr got %h want 1", wr_addr_seen); end
        n_cmp++; if (wr_data_seen !== {32'hDDDD_0001, 32'hCCCC_0001, 32'hBBBB_0001, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL dirty_wb_data got %h", wr_data_seen); end
        n_cmp++; if (rd_addr_seen !== 28'h9) begin n_bad++; $display("FAIL dirty_refill_addr got %h want 9", rd_addr_seen); end
        n_cmp++; if (rd !== 32'h9999_0000) begin n_bad++; $display("FAIL dirty_rdata got %h want 99990000", rd); end
        n_cmp++; if (st != 5) begin n_bad++; $display("FAIL dirty_stall_cycles got %0d want 5", st); end
    endtask

    task automatic test_clean_conflict();
        int st; logic [31:0] rd;
        lat = 0;
        do_access(1'b1, 1'b0, 30'h4, 32'd0, st, rd);
        n_cmp++; if (wr_cnt != 0) begin n_bad++; $display("FAIL clean_no_write got %0d want 0", wr_cnt); end
        n_cmp++; if (rd_addr_seen !== 28'h1) begin n_bad++; $display("FAIL clean_refill_addr got %h want 1", rd_addr_seen); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL clean_rdata got %h want DEADBEEF", rd); end
        n_cmp++; if (st != 2) begin n_bad++; $display("FAIL clean_stall_cycles got %0d want 2", st); end
    endtask

    task automatic test_write_miss();
        int st; logic [31:0] rd;
        lat = 0;
        do_access(1'b0, 1'b1, 30'h9, 32'h1234_5678, st, rd);
        n_cmp++; if (st != 2) begin n_bad++; $display("FAIL wmiss_stall got %0d want 2", st); end
        n_cmp++; if (rd_addr_seen !== 28'h2) begin n_bad++; $display("FAIL wmiss_refill_addr got %h want 2", rd_addr_seen); end
        do_access(1'b1, 1'b0, 30'h9, 32'd0, st, rd);
        n_cmp++; if (rd !== 32'h1234_5678 || st != 0) begin n_bad++; $display("FAIL wmiss_readback got %h/%0d want 12345678/0", rd, st); end
    endtask

    task automatic test_back_to_back();
        logic [29:0] addrs [4];
        logic [31:0] exps [4];
        logic        wrs [4];
        addrs[0] = 30'h8; exps[0] = 32'h2222_0000; wrs[0] = 1'b0;
        addrs[1] = 30'hB; exps[1] = 32'hCAFE_F00D; wrs[1] = 1'b1;
        addrs[2] = 30'hB; exps[2] = 32'hCAFE_F00D; wrs[2] = 1'b0;
        addrs[3] = 30'hA; exps[3] = 32'h2222_0002; wrs[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            proc_read  = ~wrs[i];
            proc_write = wrs[i];
            proc_addr  = addrs[i];
            proc_wdata = exps[i];
            #1;
            n_cmp++; if (proc_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall[%0d] got %b want 0", i, proc_stall); end
            if (!wrs[i]) begin
                n_cmp++; if (proc_rdata !== exps[i]) begin n_bad++; $display("FAIL b2b_rdata[%0d] got %h want %h", i, proc_rdata, exps[i]); end
            end
        end
        @(negedge clk);
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic test_reset_mid_alloc();
        int st; int cyc; logic [31:0] rd;
        lat = 10;
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'hC;
        cyc = 0;
        while (!mem_read && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rstmid_alloc_started got %b want 1", mem_read); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_mem_read got %b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rstmid_mem_write got %b want 0", mem_write); end
        @(negedge clk);
        proc_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        do_access(1'b1, 1'b0, 30'h6, 32'd0, st, rd);
        n_cmp++; if (rd_cnt == 0 || st != 2) begin n_bad++; $display("FAIL rstmid_remiss got rd=%0d stall=%0d want >0/2", rd_cnt, st); end
        n_cmp++; if (rd !== 32'hCCCC_0001) begin n_bad++; $display("FAIL rstmid_rdata got %h want CCCC0001", rd); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_m[i] = 128'd0;
        mem_m[1] = LINE1;
        mem_m[9] = LINE9;
        mem_m[2] = LINE2;
        mem_m[3] = LINE3;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_dirty_conflict();
        test_clean_conflict();
        test_write_miss();
        test_back_to_back();
        test_reset_mid_alloc();
        n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL rd_wr_exclusive got %0d overlapping cycles want 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
